// File: rtl/heap_req_scheduler_pkg.sv
// Shared opcodes, heap port constants and scheduler state type for the
// heap request scheduler slice.
package heap_pkg;

    localparam logic [1:0] OP_NOP     = 2'd0;
    localparam logic [1:0] OP_INSERT  = 2'd1;
    localparam logic [1:0] OP_EXTRACT = 2'd2;
    localparam logic [1:0] OP_PEEK    = 2'd3;

    localparam int HEAP_OP_W = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } sched_state_t;

endpackage

// File: rtl/heap_req_scheduler_arbiter.sv
// Round-robin arbiter: grants the first set request at or after ptr,
// wrapping modulo NUM_REQ; produces both a one-hot grant and its index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    int unsigned idx;
    logic        found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        if (en) begin
            for (int unsigned off = 0; off < 32'(NUM_REQ); off++) begin
                idx = 32'(ptr) + off;
                if (idx >= 32'(NUM_REQ)) begin
                    idx = idx - 32'(NUM_REQ);
                end
                if (!found && req[IDX_W'(idx)]) begin
                    found                = 1'b1;
                    grant[IDX_W'(idx)]   = 1'b1;
                    grant_idx            = IDX_W'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/heap_req_scheduler.sv
// Serialises round-robin requests from NUM_REQ clients onto a single heap,
// filtering full/empty cases and returning one tagged response per request.
module heap_req_scheduler
    import heap_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 32,
    parameter int SIZE_W   = 5,
    parameter int CAPACITY = 31
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [2*NUM_REQ-1:0]        req_op,
    input  logic [DATA_W*NUM_REQ-1:0]   req_value,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
    output logic [DATA_W-1:0]           rsp_value,
    output logic                        rsp_err,
    output logic                        heap_enable,
    output logic [HEAP_OP_W-1:0]        heap_operation,
    output logic [DATA_W-1:0]           heap_input_value,
    input  logic [SIZE_W-1:0]           heap_size,
    input  logic [DATA_W-1:0]           heap_top,
    input  logic                        heap_busy
);

    localparam int ID_W = $clog2(NUM_REQ);

    sched_state_t           state, state_d;
    logic [ID_W-1:0]        rr_ptr, rr_ptr_d;
    logic [1:0]             op_q, op_d;

    logic                   rsp_valid_d, rsp_err_d, heap_enable_d;
    logic [ID_W-1:0]        rsp_id_d;
    logic [DATA_W-1:0]      rsp_value_d, heap_input_value_d;
    logic [HEAP_OP_W-1:0]   heap_operation_d;

    logic [1:0]             op_arr  [NUM_REQ];
    logic [DATA_W-1:0]      val_arr [NUM_REQ];
    logic [NUM_REQ-1:0]     eligible;
    logic [ID_W-1:0]        grant_idx;
    logic                   arb_en, accept;
    logic [1:0]             sel_op;
    logic [DATA_W-1:0]      sel_value;
    logic                   heap_full, heap_empty;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_arr[g]   = req_op[2*g +: 2];
        assign val_arr[g]  = req_value[DATA_W*g +: DATA_W];
        assign eligible[g] = req_valid[g] && (op_arr[g] != OP_NOP);
    end

    // Grants are only offered while idle and out of reset, so no handshake
    // can complete in a cycle whose edge would discard it.
    assign arb_en = (state == S_IDLE) && !reset;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req       (eligible),
        .ptr       (rr_ptr),
        .en        (arb_en),
        .grant     (req_ready),
        .grant_idx (grant_idx)
    );

    assign accept     = |req_ready;
    assign sel_op     = op_arr[grant_idx];
    assign sel_value  = val_arr[grant_idx];
    assign heap_full  = (heap_size == SIZE_W'(CAPACITY));
    assign heap_empty = (heap_size == '0);

    always_comb begin
        state_d            = state;
        rr_ptr_d           = rr_ptr;
        op_d               = op_q;
        rsp_valid_d        = 1'b0;
        rsp_id_d           = rsp_id;
        rsp_value_d        = rsp_value;
        rsp_err_d          = rsp_err;
        heap_enable_d      = 1'b0;
        heap_operation_d   = '0;
        heap_input_value_d = '0;

        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    rr_ptr_d    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    op_d        = sel_op;
                    rsp_id_d    = grant_idx;
                    rsp_value_d = '0;
                    rsp_err_d   = 1'b0;
                    if ((sel_op == OP_INSERT && heap_full) ||
                        (sel_op != OP_INSERT && heap_empty)) begin
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end else if (sel_op == OP_PEEK) begin
                        rsp_value_d = heap_top;
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end else begin
                        heap_enable_d      = 1'b1;
                        heap_operation_d   = HEAP_OP_W'(sel_op);
                        heap_input_value_d = (sel_op == OP_INSERT) ? sel_value : '0;
                        state_d            = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // Root is still the pre-removal value during the issue cycle.
                if (op_q == OP_EXTRACT) begin
                    rsp_value_d = heap_top;
                end
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!heap_busy) begin
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            rr_ptr           <= '0;
            op_q             <= OP_NOP;
            rsp_valid        <= 1'b0;
            rsp_id           <= '0;
            rsp_value        <= '0;
            rsp_err          <= 1'b0;
            heap_enable      <= 1'b0;
            heap_operation   <= '0;
            heap_input_value <= '0;
        end else begin
            state            <= state_d;
            rr_ptr           <= rr_ptr_d;
            op_q             <= op_d;
            rsp_valid        <= rsp_valid_d;
            rsp_id           <= rsp_id_d;
            rsp_value        <= rsp_value_d;
            rsp_err          <= rsp_err_d;
            heap_enable      <= heap_enable_d;
            heap_operation   <= heap_operation_d;
            heap_input_value <= heap_input_value_d;
        end
    end

endmodule

// File: tb/tb_heap_req_scheduler.sv
// Randomised scoreboard bench for heap_req_scheduler with a behavioural
// multiset heap and a round-robin grant model.
module tb_heap_req_scheduler;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int SW  = 5;
    localparam int CAP = 31;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [2*N-1:0]    req_op;
    logic [DW*N-1:0]   req_value;
    logic [N-1:0]      req_ready;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [DW-1:0]     rsp_value;
    logic              rsp_err;
    logic              heap_enable;
    logic [4:0]        heap_operation;
    logic [DW-1:0]     heap_input_value;
    logic [SW-1:0]     heap_size;
    logic [DW-1:0]     heap_top;
    logic              heap_busy;

    heap_req_scheduler #(
        .NUM_REQ  (N),
        .DATA_W   (DW),
        .SIZE_W   (SW),
        .CAPACITY (CAP)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_op           (req_op),
        .req_value        (req_value),
        .req_ready        (req_ready),
        .rsp_valid        (rsp_valid),
        .rsp_id           (rsp_id),
        .rsp_value        (rsp_value),
        .rsp_err          (rsp_err),
        .heap_enable      (heap_enable),
        .heap_operation   (heap_operation),
        .heap_input_value (heap_input_value),
        .heap_size        (heap_size),
        .heap_top         (heap_top),
        .heap_busy        (heap_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] value;
        logic        err;
        bit          uses_heap;
        int          hs_cyc;
    } rsp_t;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] value;
    } iss_t;

    rsp_t        sb_q[$];
    iss_t        iss_q[$];
    int unsigned heap_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rr_model = 0;
    bit in_flight = 0;
    int last_k = 0;
    int force_k = -1;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void flag(string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endfunction

    function automatic int unsigned model_min();
        int unsigned m;
        m = heap_q[0];
        foreach (heap_q[i]) if (heap_q[i] < m) m = heap_q[i];
        return m;
    endfunction

    function automatic void update_heap_ports();
        heap_size = SW'(heap_q.size());
        heap_top  = (heap_q.size() > 0) ? DW'(model_min()) : '0;
    endfunction

    // Behavioural heap: applies issued ops after the issue edge, then stays busy k cycles.
    initial begin
        logic [4:0]  h_op;
        logic [31:0] h_val;
        logic        rst_at_edge;
        int          k;
        heap_busy = 1'b0;
        heap_size = '0;
        heap_top  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                heap_q.delete();
                heap_busy = 1'b0;
                update_heap_ports();
            end else if (heap_enable) begin
                h_op        = heap_operation;
                h_val       = heap_input_value;
                rst_at_edge = reset;
                @(posedge clk);
                #1;
                if (!rst_at_edge) begin
                    if (h_op == 5'd1) begin
                        if (heap_q.size() >= CAP) flag("heap_insert_when_full");
                        else heap_q.push_back(h_val);
                    end else if (h_op == 5'd2) begin
                        if (heap_q.size() == 0) flag("heap_extract_when_empty");
                        else begin
                            int unsigned m;
                            m = model_min();
                            foreach (heap_q[i]) if (heap_q[i] == m) begin heap_q.delete(i); break; end
                        end
                    end
                    update_heap_ports();
                    k = (force_k >= 0) ? force_k : int'($urandom_range(0, 3));
                    last_k = k;
                    if (k > 0) begin
                        heap_busy = 1'b1;
                        for (int j = 0; j < k; j++) begin
                            @(negedge clk);
                            if (reset) break;
                            @(posedge clk);
                            #1;
                        end
                        heap_busy = 1'b0;
                        if (reset) begin
                            heap_q.delete();
                            update_heap_ports();
                        end
                    end
                end
            end
        end
    end

    // Monitor / scoreboard: grant order, issued heap ops, responses and latency.
    always @(negedge clk) begin
        logic [N-1:0] elig, exp_grant, hs;
        cyc++;
        elig = '0;
        for (int i = 0; i < N; i++) elig[i] = req_valid[i] && (req_op[2*i +: 2] != 2'd0);
        exp_grant = '0;
        if (!reset && !in_flight) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (rr_model + k) % N;
                if (elig[j]) begin exp_grant[j] = 1'b1; break; end
            end
        end
        check("req_ready", req_ready, exp_grant);

        if (heap_enable) begin
            if (iss_q.size() == 0) flag("unexpected_heap_enable");
            else begin
                iss_t e;
                e = iss_q.pop_front();
                check("heap_operation", heap_operation, e.op);
                check("heap_input_value", heap_input_value, e.value);
            end
        end

        if (rsp_valid) begin
            if (sb_q.size() == 0) flag("unexpected_rsp_valid");
            else begin
                rsp_t e;
                int exp_lat;
                e = sb_q.pop_front();
                exp_lat = e.uses_heap ? 3 + last_k : 1;
                check("rsp_id", rsp_id, e.id);
                check("rsp_value", rsp_value, e.value);
                check("rsp_err", rsp_err, e.err);
                check("rsp_latency", cyc - e.hs_cyc, exp_lat);
            end
            in_flight = 0;
        end

        hs = req_ready & req_valid;
        if (!reset && hs != '0) begin
            int id;
            logic [1:0] op;
            logic [31:0] val;
            rsp_t r;
            id = 0;
            for (int i = N - 1; i >= 0; i--) if (hs[i]) id = i;
            op  = req_op[2*id +: 2];
            val = req_value[DW*id +: DW];
            r.id = id; r.value = '0; r.err = 1'b0; r.uses_heap = 0; r.hs_cyc = cyc;
            if (op == 2'd1 && heap_q.size() == CAP) r.err = 1'b1;
            else if (op != 2'd1 && heap_q.size() == 0) r.err = 1'b1;
            else if (op == 2'd3) r.value = model_min();
            else begin
                iss_t is;
                r.uses_heap = 1;
                if (op == 2'd2) r.value = model_min();
                is.op    = 5'(op);
                is.value = (op == 2'd1) ? val : '0;
                iss_q.push_back(is);
            end
            sb_q.push_back(r);
            in_flight = 1;
            rr_model  = (id + 1) % N;
        end

        if (reset) begin
            sb_q.delete();
            iss_q.delete();
            in_flight = 0;
            rr_model  = 0;
        end
    end

    task automatic check_all_zero(string tag);
        check({tag, "_req_ready"}, req_ready, '0);
        check({tag, "_rsp_valid"}, rsp_valid, '0);
        check({tag, "_rsp_id"}, rsp_id, '0);
        check({tag, "_rsp_value"}, rsp_value, '0);
        check({tag, "_rsp_err"}, rsp_err, '0);
        check({tag, "_heap_enable"}, heap_enable, '0);
        check({tag, "_heap_operation"}, heap_operation, '0);
        check({tag, "_heap_input_value"}, heap_input_value, '0);
    endtask

    task automatic run_phase(int cycles, int p_valid, int w_ins, int w_ext);
        repeat (cycles) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                int r;
                req_valid[i] = ($urandom_range(0, 99) < p_valid);
                r = int'($urandom_range(0, 99));
                if (r < 5) req_op[2*i +: 2] = 2'd0;
                else if (r < 5 + w_ins) req_op[2*i +: 2] = 2'd1;
                else if (r < 5 + w_ins + w_ext) req_op[2*i +: 2] = 2'd2;
                else req_op[2*i +: 2] = 2'd3;
                req_value[DW*i +: DW] = DW'($urandom_range(0, 999));
            end
        end
    endtask

    task automatic drain();
        @(posedge clk);
        #1;
        req_valid = '0;
        for (int t = 0; t < 100 && in_flight; t++) @(posedge clk);
        @(negedge clk);
        if (in_flight) flag("drain_timeout");
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_value = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_phase(400, 70, 80, 10);
        run_phase(400, 70, 10, 75);
        run_phase(300, 60, 40, 40);
        drain();

        // Reset while waiting on a busy heap drops the pending response.
        @(posedge clk);
        #1;
        force_k = 4;
        req_valid = 4'b0010;
        req_op[3:2] = 2'd1;
        req_value[63:32] = 32'd77;
        begin
            bit seen;
            seen = 0;
            for (int t = 0; t < 20 && !seen; t++) begin
                @(negedge clk);
                seen = heap_enable;
            end
            if (!seen) flag("directed_issue_timeout");
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("midop_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        force_k = -1;
        req_valid = 4'b1001;
        req_op = {2'd1, 2'd0, 2'd0, 2'd1};
        req_value = {32'd9, 32'd0, 32'd0, 32'd3};
        @(negedge clk);
        check("post_reset_grant", req_ready, 4'b0001);
        drain();
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

endmodule
